// File: rtl/bitwise_alu_pipe.sv
// ---------------------------------------------------------------------------
// bitwise_alu_pipe
//
// Pipelined bitwise ALU. One of eight bitwise operations is applied to two
// WIDTH-bit operands; the result plus its zero and parity flags travel
// through a STAGES-deep register pipeline with full backpressure. A chained
// mode substitutes the previous accepted result (the accumulator) for
// operand b.
//
// Handshake semantics (both sides): a beat transfers on a rising edge where
// valid && ready are both 1. A producer holding valid=1 keeps its payload
// stable until the transfer; ready may depend combinationally on the far
// side (in_ready is combinational from out_ready through the pipeline).
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   in_valid    operand beat present
//   in_ready    block accepts the beat this cycle
//   in_a        operand a
//   in_b        operand b (ignored when in_chain=1)
//   in_op       operation select (AND OR XOR NAND NOR XNOR ANDN PASS)
//   in_chain    1 = use the accumulator in place of in_b
//   out_valid   result beat present
//   out_ready   downstream accepts the result
//   out_result  operation result
//   out_zero    1 when out_result == 0
//   out_parity  XOR-reduction of out_result
// ---------------------------------------------------------------------------
module bitwise_alu_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_chain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_parity
);

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_ANDN = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    // Pipeline state
    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [STAGES-1:0] zero_q;
    logic [STAGES-1:0] par_q;
    logic [WIDTH-1:0]  acc_q;
    logic [WIDTH-1:0]  acc_d;

    // Combinational datapath / control
    logic [STAGES-1:0] load;     // stage i takes new contents this cycle
    logic [WIDTH-1:0]  b_eff;
    logic [WIDTH-1:0]  res_d;
    logic              accept;

    // Stage i can load when it, or any stage downstream of it, has a hole,
    // or when the last stage is being drained. Walking from the output back
    // toward the input gives this without a self-referencing vector.
    always_comb begin
        logic rdy;
        rdy  = out_ready;
        load = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            rdy     = rdy || !valid_q[i];
            load[i] = rdy;
        end
    end

    assign in_ready = load[0] && !rst;
    assign accept   = in_valid && in_ready;

    // The accumulator always holds the latest accepted result, so a chained
    // beat directly behind another sees that result with no bubble.
    assign b_eff = in_chain ? acc_q : in_b;

    always_comb begin
        res_d = in_a;
        case (op_e'(in_op))
            OP_AND:  res_d = in_a & b_eff;
            OP_OR:   res_d = in_a | b_eff;
            OP_XOR:  res_d = in_a ^ b_eff;
            OP_NAND: res_d = ~(in_a & b_eff);
            OP_NOR:  res_d = ~(in_a | b_eff);
            OP_XNOR: res_d = ~(in_a ^ b_eff);
            OP_ANDN: res_d = in_a & ~b_eff;
            OP_PASS: res_d = in_a;
            default: res_d = in_a;
        endcase
    end

    assign acc_d = accept ? res_d : acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            acc_q   <= '0;
            zero_q  <= '1;   // cleared result is zero, so its flag reads 1
            par_q   <= '0;
            for (int i = 0; i < STAGES; i++) begin
                res_q[i] <= '0;
            end
        end else begin
            acc_q <= acc_d;

            // Stage 0: flags are computed once here and only copied later.
            if (load[0]) begin
                valid_q[0] <= accept;
            end
            if (accept) begin
                res_q[0]  <= res_d;
                zero_q[0] <= ~|res_d;
                par_q[0]  <= ^res_d;
            end

            // Stages 1..STAGES-1: pure delay. Payload only moves with a valid
            // beat so an empty stage keeps its last contents.
            for (int i = 1; i < STAGES; i++) begin
                if (load[i]) begin
                    valid_q[i] <= valid_q[i-1];
                    if (valid_q[i-1]) begin
                        res_q[i]  <= res_q[i-1];
                        zero_q[i] <= zero_q[i-1];
                        par_q[i]  <= par_q[i-1];
                    end
                end
            end
        end
    end

    assign out_valid  = valid_q[STAGES-1];
    assign out_result = res_q[STAGES-1];
    assign out_zero   = zero_q[STAGES-1];
    assign out_parity = par_q[STAGES-1];

endmodule

// File: tb/tb_bitwise_alu_pipe.sv
// Bench for bitwise_alu_pipe: three instances (32/2, 32/3, 1/1) share one clock.
module tb_bitwise_alu_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A: WIDTH=32, STAGES=2 ----------------
    logic        a_rst, a_in_valid, a_in_ready, a_in_chain;
    logic [31:0] a_in_a, a_in_b, a_out_result;
    logic [2:0]  a_in_op;
    logic        a_out_valid, a_out_ready, a_out_zero, a_out_parity;
    logic [31:0] a_exp_q[$];

    bitwise_alu_pipe #(.WIDTH(32), .STAGES(2)) u_a (
        .clk(clk), .rst(a_rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_a(a_in_a), .in_b(a_in_b), .in_op(a_in_op), .in_chain(a_in_chain),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_result(a_out_result), .out_zero(a_out_zero), .out_parity(a_out_parity)
    );

    // ---------------- instance B: WIDTH=32, STAGES=3 ----------------
    logic        b_rst, b_in_valid, b_in_ready, b_in_chain;
    logic [31:0] b_in_a, b_in_b, b_out_result;
    logic [2:0]  b_in_op;
    logic        b_out_valid, b_out_ready, b_out_zero, b_out_parity;
    logic [31:0] b_exp_q[$];
    int          b_emits    = 0;
    int          b_last_cyc = 0;

    bitwise_alu_pipe #(.WIDTH(32), .STAGES(3)) u_b (
        .clk(clk), .rst(b_rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_a(b_in_a), .in_b(b_in_b), .in_op(b_in_op), .in_chain(b_in_chain),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_result(b_out_result), .out_zero(b_out_zero), .out_parity(b_out_parity)
    );

    // ---------------- instance C: WIDTH=1, STAGES=1 ----------------
    logic       c_rst, c_in_valid, c_in_ready, c_in_chain;
    logic       c_in_a, c_in_b, c_out_result;
    logic [2:0] c_in_op;
    logic       c_out_valid, c_out_ready, c_out_zero, c_out_parity;

    bitwise_alu_pipe #(.WIDTH(1), .STAGES(1)) u_c (
        .clk(clk), .rst(c_rst),
        .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_a(c_in_a), .in_b(c_in_b), .in_op(c_in_op), .in_chain(c_in_chain),
        .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_result(c_out_result), .out_zero(c_out_zero), .out_parity(c_out_parity)
    );

    // Hand truth table, bit index = {a,b}
    logic [3:0] tt [8] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111,
                           4'b0001, 4'b1001, 4'b0100, 4'b1100};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboards ----------------
    always @(negedge clk) begin
        if (!a_rst && a_out_valid && a_out_ready) begin
            checks++;
            assert (a_exp_q.size() != 0) else begin
                failures++;
                $error("FAIL a_extra_beat observed=%0h expected=none", a_out_result);
            end
            if (a_exp_q.size() != 0) begin
                logic [31:0] e;
                e = a_exp_q.pop_front();
                check("a_result", a_out_result, e);
                check("a_zero", 32'(a_out_zero), 32'(e == 32'd0));
                check("a_parity", 32'(a_out_parity), 32'(^e));
            end
        end
    end

    always @(negedge clk) begin
        if (!b_rst && b_out_valid && b_out_ready) begin
            if (b_emits > 0) check("b_no_gap", 32'(cyc - b_last_cyc), 32'd1);
            b_last_cyc = cyc;
            b_emits++;
            checks++;
            assert (b_exp_q.size() != 0) else begin
                failures++;
                $error("FAIL b_extra_beat observed=%0h expected=none", b_out_result);
            end
            if (b_exp_q.size() != 0) check("b_result", b_out_result, b_exp_q.pop_front());
        end
    end

    // ---------------- driver tasks (entered at posedge+1) ----------------
    task automatic a_beat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic ch, input logic [31:0] exp);
        logic done;
        done = 1'b0;
        a_in_op = op; a_in_a = a; a_in_b = b; a_in_chain = ch; a_in_valid = 1'b1;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk);
            if (a_in_ready) begin
                a_exp_q.push_back(exp);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        check("a_accept", 32'(done), 32'd1);
    endtask

    task automatic a_drain();
        a_in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("a_drained", 32'(a_exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic b_set(input int k);
        b_in_op = 3'b010; b_in_a = 32'(k); b_in_b = 32'hFFFF_0000; b_in_chain = 1'b0;
    endtask

    int k;
    int b_acc;

    initial begin
        a_rst = 1; b_rst = 1; c_rst = 1;
        a_in_valid = 0; b_in_valid = 0; c_in_valid = 0;
        a_in_a = 0; a_in_b = 0; a_in_op = 0; a_in_chain = 0; a_out_ready = 1;
        b_in_a = 0; b_in_b = 0; b_in_op = 0; b_in_chain = 0; b_out_ready = 1;
        c_in_a = 0; c_in_b = 0; c_in_op = 0; c_in_chain = 0; c_out_ready = 1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(a_in_ready), 32'd0);
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_out_result", a_out_result, 32'd0);
        check("rst_out_zero", 32'(a_out_zero), 32'd1);
        check("rst_out_parity", 32'(a_out_parity), 32'd0);
        check("rst_c_out_valid", 32'(c_out_valid), 32'd0);
        @(posedge clk); #1;
        a_rst = 0; b_rst = 0; c_rst = 0;
        @(negedge clk);
        check("post_rst_in_ready_a", 32'(a_in_ready), 32'd1);
        check("post_rst_in_ready_b", 32'(b_in_ready), 32'd1);
        @(posedge clk); #1;

        // Latency: two edges from accept to out_valid
        a_beat(3'b111, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'hDEAD_BEEF);
        a_in_valid = 0;
        @(negedge clk);
        check("a_lat_one_edge", 32'(a_out_valid), 32'd0);
        @(negedge clk);
        check("a_lat_two_edges", 32'(a_out_valid), 32'd1);
        @(posedge clk); #1;

        // Basic ops back-to-back
        a_beat(3'b000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0, 32'h00F0_000F);
        a_beat(3'b001, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0, 32'hFFF0_0FFF);
        a_beat(3'b010, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0, 32'hFF00_0FF0);
        a_beat(3'b011, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0, 32'hFF0F_FFF0);
        a_beat(3'b100, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0, 32'h000F_F000);
        a_beat(3'b101, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0, 32'h00FF_F00F);
        a_beat(3'b110, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0, 32'hF000_00F0);
        a_beat(3'b111, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0, 32'hF0F0_00FF);
        a_drain();

        // Chained accumulate, back-to-back
        a_beat(3'b001, 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003);
        a_beat(3'b010, 32'h0000_00FF, 32'hFFFF_FFFF, 1'b1, 32'h0000_00FC);
        a_beat(3'b000, 32'h0000_000F, 32'hFFFF_FFFF, 1'b1, 32'h0000_000C);
        a_drain();

        // Flags
        a_beat(3'b000, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 32'h0000_0000);
        a_beat(3'b010, 32'h0000_0007, 32'h0000_0000, 1'b0, 32'h0000_0007);
        a_drain();

        // Stall: capacity 2, held output stable
        a_out_ready = 0;
        a_beat(3'b111, 32'h1111_1111, 32'h0, 1'b0, 32'h1111_1111);
        a_beat(3'b111, 32'h2222_2222, 32'h0, 1'b0, 32'h2222_2222);
        a_in_op = 3'b111; a_in_a = 32'h3333_3333; a_in_valid = 1;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            check("a_stall_in_ready", 32'(a_in_ready), 32'd0);
            check("a_stall_out_valid", 32'(a_out_valid), 32'd1);
            check("a_stall_hold_result", a_out_result, 32'h1111_1111);
            check("a_stall_hold_zero", 32'(a_out_zero), 32'd0);
            @(posedge clk); #1;
        end
        a_out_ready = 1;
        a_beat(3'b111, 32'h3333_3333, 32'h0, 1'b0, 32'h3333_3333);
        a_drain();

        // Reset mid-stream
        a_out_ready = 0;
        a_beat(3'b111, 32'h4444_4444, 32'h0, 1'b0, 32'h4444_4444);
        a_beat(3'b111, 32'h5555_5555, 32'h0, 1'b0, 32'h5555_5555);
        a_in_valid = 0;
        a_rst = 1;
        @(posedge clk); #1;
        a_rst = 0;
        a_exp_q.delete();
        a_out_ready = 1;
        repeat (3) begin
            @(negedge clk);
            check("a_rst_no_out", 32'(a_out_valid), 32'd0);
        end
        @(posedge clk); #1;
        a_beat(3'b001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000);
        a_drain();

        // Backpressure on STAGES=3: 5 beats offered with output blocked
        b_out_ready = 0;
        k = 1; b_acc = 0;
        b_set(1); b_in_valid = 1;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (b_in_ready && k <= 5) begin
                b_exp_q.push_back(32'hFFFF_0000 | 32'(k));
                b_acc++; k++;
            end
            @(posedge clk); #1;
            if (k <= 5) b_set(k); else b_in_valid = 0;
        end
        check("b_accepted_when_blocked", 32'(b_acc), 32'd3);
        @(negedge clk);
        check("b_in_ready_full", 32'(b_in_ready), 32'd0);
        check("b_no_emit_blocked", 32'(b_emits), 32'd0);
        @(posedge clk); #1;
        b_out_ready = 1;
        for (int t = 0; t < 10 && k <= 5; t++) begin
            @(negedge clk);
            if (b_in_ready && k <= 5) begin
                b_exp_q.push_back(32'hFFFF_0000 | 32'(k));
                b_acc++; k++;
            end
            @(posedge clk); #1;
            if (k <= 5) b_set(k); else b_in_valid = 0;
        end
        b_in_valid = 0;
        repeat (6) @(negedge clk);
        check("b_accepted_total", 32'(b_acc), 32'd5);
        check("b_emitted_total", 32'(b_emits), 32'd5);
        check("b_drained", 32'(b_exp_q.size()), 32'd0);
        @(posedge clk); #1;

        // WIDTH=1, STAGES=1 exhaustive truth table, 1-cycle latency
        for (int op = 0; op < 8; op++) begin
            for (int ab = 0; ab < 4; ab++) begin
                c_in_op = 3'(op); c_in_a = ab[1]; c_in_b = ab[0]; c_in_valid = 1;
                @(negedge clk);
                check("c_in_ready", 32'(c_in_ready), 32'd1);
                @(posedge clk); #1;
                c_in_valid = 0;
                @(negedge clk);
                check("c_out_valid", 32'(c_out_valid), 32'd1);
                check("c_result", 32'(c_out_result), 32'(tt[op][ab]));
                check("c_zero", 32'(c_out_zero), 32'(!tt[op][ab]));
                check("c_parity", 32'(c_out_parity), 32'(tt[op][ab]));
                @(posedge clk); #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
